// File: rtl/nd_1to2.sv
// nd_1to2: one inbound four-phase channel routed to two outbound channels by address.
// Each output owns a FIFO, so one stalled consumer only blocks the input once its FIFO fills.
module nd_1to2 #(
  parameter int FSZ = 4,
  parameter int ASZ = 4,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv0_addr,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd0_addr,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd1_req,
  input  logic           snd1_ack,
  output logic [ASZ-1:0] snd1_addr,
  output logic [DSZ-1:0] snd1_dat,
  output logic [RSZ-1:0] snd1_red
);
  localparam int PW = $clog2(FSZ);
  localparam int MW = ASZ + DSZ + RSZ;
  localparam logic [ASZ-1:0] SPLIT_ADDR = {1'b1, {(ASZ-1){1'b0}}};
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [MW-1:0] mem [2][FSZ];
  logic [PW:0]   head [2];
  logic [PW:0]   tail [2];
  logic [MW-1:0] msg [2];
  logic [1:0]    req;
  logic [1:0]    busy;
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    out_ack;
  logic          tgt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    out_ack = {snd1_ack, snd0_ack};
    tgt     = (rcv0_addr >= SPLIT_ADDR);
    full    = '0;
    empty   = '0;
    for (int k = 0; k < 2; k++) begin
      empty[k] = (head[k] == tail[k]);
      full[k]  = (head[k][PW] != tail[k][PW]) &&
                 (head[k][PW-1:0] == tail[k][PW-1:0]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset || !ready) begin
      ready    <= !reset;
      rcv0_ack <= 1'b0;
      req      <= '0;
      busy     <= '0;
      for (int k = 0; k < 2; k++) begin
        head[k] <= '0;
        tail[k] <= '0;
        msg[k]  <= '0;
      end
    end else begin
      if (rcv0_req && !rcv0_ack && !full[tgt]) begin
        mem[tgt][head[tgt][PW-1:0]] <= {rcv0_addr, rcv0_dat, rcv0_red};
        head[tgt] <= head[tgt] + PTR_ONE;
        rcv0_ack  <= 1'b1;
      end else if (!rcv0_req && rcv0_ack) begin
        rcv0_ack <= 1'b0;
      end

      // busy stays set until the receiver drops ack, closing the four-phase cycle.
      for (int k = 0; k < 2; k++) begin
        if (req[k]) begin
          if (out_ack[k]) req[k] <= 1'b0;
        end else if (busy[k]) begin
          if (!out_ack[k]) busy[k] <= 1'b0;
        end else if (!empty[k] && !out_ack[k]) begin
          msg[k]  <= mem[k][tail[k][PW-1:0]];
          tail[k] <= tail[k] + PTR_ONE;
          req[k]  <= 1'b1;
          busy[k] <= 1'b1;
        end
      end
    end
  end

  assign snd0_req = req[0];
  assign snd1_req = req[1];
  assign {snd0_addr, snd0_dat, snd0_red} = msg[0];
  assign {snd1_addr, snd1_dat, snd1_red} = msg[1];

endmodule

// File: tb/tb_nd_1to2.sv
// Bench for nd_1to2: directed steps plus random traffic checked against per-output queues.
module tb_nd_1to2;
  logic       i_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready;
  logic       rcv0_req = 1'b0;
  logic       rcv0_ack;
  logic [3:0] rcv0_addr = '0;
  logic [7:0] rcv0_dat = '0;
  logic [3:0] rcv0_red = '0;
  logic       snd0_req, snd1_req;
  logic       snd0_ack = 1'b0, snd1_ack = 1'b0;
  logic [3:0] snd0_addr, snd1_addr;
  logic [7:0] snd0_dat, snd1_dat;
  logic [3:0] snd0_red, snd1_red;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] q0[$], q1[$];
  int sent0 = 0, sent1 = 0, got0 = 0, got1 = 0, rise1 = 0;
  bit rx_en0 = 1'b1, rx_en1 = 1'b1;
  int unsigned rx_max = 0;

  nd_1to2 #(.FSZ(4), .ASZ(4), .DSZ(8), .RSZ(4)) dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
    .rcv0_addr(rcv0_addr), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
    .snd0_req(snd0_req), .snd0_ack(snd0_ack),
    .snd0_addr(snd0_addr), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
    .snd1_req(snd1_req), .snd1_ack(snd1_ack),
    .snd1_addr(snd1_addr), .snd1_dat(snd1_dat), .snd1_red(snd1_red)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge snd1_req) rise1++;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference routing rule: addresses 8..15 go to output 1, the rest to output 0.
  task automatic push_model();
    logic [15:0] m;
    m = {rcv0_addr, rcv0_dat, rcv0_red};
    if (rcv0_addr >= 4'd8) begin q1.push_back(m); sent1++; end
    else begin q0.push_back(m); sent0++; end
  endtask

  task automatic put(input logic [3:0] a, input logic [7:0] d, input logic [3:0] r);
    rcv0_addr = a;
    rcv0_dat  = d;
    rcv0_red  = r;
    rcv0_req  = 1'b1;
  endtask

  task automatic wait_ack(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge i_clk);
      if (rcv0_ack) begin ok = 1'b1; break; end
    end
    if (ok) begin
      push_model();
      rcv0_req = 1'b0;
      for (int i = 0; i < 10 && rcv0_ack; i++) @(negedge i_clk);
    end
  endtask

  task automatic send(input logic [3:0] a);
    bit ok;
    put(a, 8'($urandom), 4'($urandom));
    wait_ack(50, ok);
    chk("send_ack", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || snd0_req || snd1_req ||
            snd0_ack || snd1_ack) && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic rx(input bit k);
    logic [15:0] obs, exp_m;
    forever begin
      @(negedge i_clk);
      if (k ? (snd1_req && !snd1_ack && rx_en1) : (snd0_req && !snd0_ack && rx_en0)) begin
        obs = k ? {snd1_addr, snd1_dat, snd1_red} : {snd0_addr, snd0_dat, snd0_red};
        if (k) begin
          if (q1.size() == 0) chk("rx1_unexpected", 32'(obs), 32'hFFFF_FFFF);
          else begin exp_m = q1.pop_front(); chk("rx1_msg", 32'(obs), 32'(exp_m)); end
          got1++;
        end else begin
          if (q0.size() == 0) chk("rx0_unexpected", 32'(obs), 32'hFFFF_FFFF);
          else begin exp_m = q0.pop_front(); chk("rx0_msg", 32'(obs), 32'(exp_m)); end
          got0++;
        end
        repeat ($urandom_range(rx_max, 0)) @(negedge i_clk);
        if (k) snd1_ack = 1'b1; else snd0_ack = 1'b1;
      end else if (k ? (!snd1_req && snd1_ack) : (!snd0_req && snd0_ack)) begin
        if (k) snd1_ack = 1'b0; else snd0_ack = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0] a, first;
    bit ok, k;
    int r0, g0, g1;

    fork
      rx(1'b0);
      rx(1'b1);
    join_none

    // Reset held 3 cycles, then released
    repeat (3) begin
      @(negedge i_clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_handshake", 32'({rcv0_ack, snd0_req, snd1_req}), 32'd0);
    end
    reset = 1'b0;
    #1 chk("ready_first_cycle", 32'(ready), 32'd0);
    @(negedge i_clk);
    chk("ready_second_cycle", 32'(ready), 32'd1);

    // Routing and 2-cycle latency with immediate acks
    rx_max = 0;
    for (int i = 0; i < 2; i++) begin
      k = (i == 1);
      a = k ? 4'd12 : 4'd3;
      put(a, 8'($urandom), 4'($urandom));
      @(negedge i_clk);
      chk("lat_ack", 32'(rcv0_ack), 32'd1);
      chk("lat_req_early", 32'(k ? snd1_req : snd0_req), 32'd0);
      push_model();
      rcv0_req = 1'b0;
      @(negedge i_clk);
      chk("lat_req", 32'(k ? snd1_req : snd0_req), 32'd1);
      chk("lat_addr", 32'(k ? snd1_addr : snd0_addr), 32'(a));
      chk("lat_ack_low", 32'(rcv0_ack), 32'd0);
    end
    drain("s2");
    chk("s2_got0", 32'(got0), 32'd1);
    chk("s2_got1", 32'(got1), 32'd1);

    // Output 1 stalled: one in flight, four buffered, sixth refused
    rx_en1 = 1'b0;
    r0 = rise1;
    first = '0;
    for (int i = 0; i < 5; i++) begin
      put(4'd8 + 4'($urandom_range(7, 0)), 8'($urandom), 4'($urandom));
      if (i == 0) first = rcv0_addr;
      wait_ack(20, ok);
      chk("s3_buffered", 32'(ok), 32'd1);
    end
    put(4'd8 + 4'($urandom_range(7, 0)), 8'($urandom), 4'($urandom));
    wait_ack(20, ok);
    chk("s3_full_noack", 32'(ok), 32'd0);
    chk("s3_req1_held", 32'(snd1_req), 32'd1);
    chk("s3_first_out", 32'(snd1_addr), 32'(first));
    chk("s3_one_rise", 32'(rise1 - r0), 32'd1);
    chk("s4_snd0_idle", 32'(snd0_req), 32'd0);
    g0 = got0;
    g1 = got1;
    rx_max = 2;
    rx_en1 = 1'b1;
    wait_ack(200, ok);
    chk("s3_sixth_acked", 32'(ok), 32'd1);
    send(4'd0);
    drain("s3");
    chk("s3_drained", 32'(got1 - g1), 32'd6);
    chk("s4_addr0_out", 32'(got0 - g0), 32'd1);

    // Alternating then fully random traffic with random ack delays
    rx_max = 3;
    for (int i = 0; i < 41; i++) begin
      if (i >= 11) a = 4'($urandom);
      else if (i % 2 == 1) a = 4'd8 + 4'($urandom_range(7, 0));
      else a = 4'($urandom_range(7, 0));
      send(a);
    end
    drain("s5");
    chk("s5_total0", 32'(got0), 32'(sent0));
    chk("s5_total1", 32'(got1), 32'(sent1));

    // Reset with snd0_req high and two messages buffered in FIFO0
    rx_max = 0;
    rx_en0 = 1'b0;
    for (int i = 0; i < 3; i++) send(4'($urandom_range(7, 0)));
    @(negedge i_clk);
    chk("s6_req0_pre", 32'(snd0_req), 32'd1);
    reset = 1'b1;
    @(negedge i_clk);
    chk("s6_req0_cleared", 32'(snd0_req), 32'd0);
    chk("s6_ack_cleared", 32'(rcv0_ack), 32'd0);
    chk("s6_ready_low", 32'(ready), 32'd0);
    q0.delete();
    sent0 = got0;
    reset = 1'b0;
    #1 chk("s6_ready_first", 32'(ready), 32'd0);
    @(negedge i_clk);
    chk("s6_ready_second", 32'(ready), 32'd1);
    rx_en0 = 1'b1;
    send(4'd5);
    send(4'd13);
    drain("s6");
    chk("s6_total0", 32'(got0), 32'(sent0));
    chk("s6_total1", 32'(got1), 32'(sent1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
